// File: rtl/mem_block_copy_master_if.sv
// rtl/mem_block_copy_master_if.sv - minimal single-channel memory bus (oe/we/addr/Wdata/size, Rdata/DataRdy)
//
// Purpose: bundles the memory-side signals of the block copy master.
// Signals:
//   Mout_oe_ram         read request (master -> slave)
//   Mout_we_ram         write request (master -> slave)
//   Mout_addr_ram       access byte address (master -> slave)
//   Mout_Wdata_ram      write data (master -> slave)
//   Mout_data_ram_size  access size in bits, 0 when idle (master -> slave)
//   M_Rdata_ram         read data (slave -> master)
//   M_DataRdy           access-complete strobe (slave -> master)
// Modports: master (the copy engine), slave (the memory responder).

interface mem_block_copy_master_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              Mout_oe_ram;
   logic              Mout_we_ram;
   logic [ADDR_W-1:0] Mout_addr_ram;
   logic [DATA_W-1:0] Mout_Wdata_ram;
   logic [5:0]        Mout_data_ram_size;
   logic [DATA_W-1:0] M_Rdata_ram;
   logic              M_DataRdy;

   modport master (
      output Mout_oe_ram,
      output Mout_we_ram,
      output Mout_addr_ram,
      output Mout_Wdata_ram,
      output Mout_data_ram_size,
      input  M_Rdata_ram,
      input  M_DataRdy
   );

   modport slave (
      input  Mout_oe_ram,
      input  Mout_we_ram,
      input  Mout_addr_ram,
      input  Mout_Wdata_ram,
      input  Mout_data_ram_size,
      output M_Rdata_ram,
      output M_DataRdy
   );
endinterface

// File: rtl/mem_block_copy_master.sv
// rtl/mem_block_copy_master.sv - word-by-word memory block copy initiator
//
// Purpose: copies n_words consecutive DATA_W-bit words from src_addr to
// dst_addr over the minimal oe/we memory bus: one read, then one write,
// per word. Start/done follow the start_port/done_port pulse handshake.
// Optional feature macro: MEM_BLOCK_COPY_TIMEOUT_EN adds a per-access
// watchdog; after TIMEOUT_CYCLES waiting cycles the request is dropped and
// the copy ends with done_port=1, error=1. Without it the block waits
// indefinitely and error stays 0.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   start_port  one-cycle start pulse, sampled only in IDLE
//   src_addr    first source byte address, latched on start
//   dst_addr    first destination byte address, latched on start
//   n_words     number of words to copy, latched on start
//   done_port   one-cycle completion pulse
//   error       valid with done_port; 1 = copy aborted
//   mem         memory bus, master modport of mem_block_copy_master_if

module mem_block_copy_master #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32,
   parameter int LEN_W          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start_port,
   input  logic [ADDR_W-1:0]       src_addr,
   input  logic [ADDR_W-1:0]       dst_addr,
   input  logic [LEN_W-1:0]        n_words,
   output logic                    done_port,
   output logic                    error,
   mem_block_copy_master_if.master mem
);

   if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mem_block_copy_master: DATA_W must be 8/16/32 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   // Byte-address increment per word; wraps modulo 2^ADDR_W.
   localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(DATA_W / 8);
   localparam logic [5:0]        ACCESS_BITS = 6'(DATA_W);

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  remaining;

`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_count;
`endif

   // Mout_Wdata_ram doubles as the data register: the read word is captured
   // straight into it, so it is already stable when the write request rises.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                  <= IDLE;
         src_ptr                <= '0;
         dst_ptr                <= '0;
         remaining              <= '0;
         done_port              <= 1'b0;
         error                  <= 1'b0;
         mem.Mout_oe_ram        <= 1'b0;
         mem.Mout_we_ram        <= 1'b0;
         mem.Mout_addr_ram      <= '0;
         mem.Mout_Wdata_ram     <= '0;
         mem.Mout_data_ram_size <= '0;
`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
         wd_count               <= '0;
`endif
      end else begin
         done_port <= 1'b0;
         error     <= 1'b0;
         case (state)
            IDLE: begin
               if (start_port) begin
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= n_words;
                  if (n_words == '0) begin
                     state     <= DONE;
                     done_port <= 1'b1;
                  end else begin
                     state                  <= RD;
                     mem.Mout_oe_ram        <= 1'b1;
                     mem.Mout_addr_ram      <= src_addr;
                     mem.Mout_data_ram_size <= ACCESS_BITS;
`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
                     wd_count               <= '0;
`endif
                  end
               end
            end

            RD: begin
               if (mem.M_DataRdy) begin
                  state              <= WR;
                  mem.Mout_oe_ram    <= 1'b0;
                  mem.Mout_we_ram    <= 1'b1;
                  mem.Mout_addr_ram  <= dst_ptr;
                  mem.Mout_Wdata_ram <= mem.M_Rdata_ram;
`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
                  wd_count           <= '0;
               end else if (wd_count == WD_LAST) begin
                  state                  <= DONE;
                  done_port              <= 1'b1;
                  error                  <= 1'b1;
                  mem.Mout_oe_ram        <= 1'b0;
                  mem.Mout_addr_ram      <= '0;
                  mem.Mout_data_ram_size <= '0;
               end else begin
                  wd_count <= wd_count + WD_W'(1);
`endif
               end
            end

            WR: begin
               if (mem.M_DataRdy) begin
                  src_ptr         <= src_ptr + STEP;
                  dst_ptr         <= dst_ptr + STEP;
                  remaining       <= remaining - LEN_W'(1);
                  mem.Mout_we_ram <= 1'b0;
                  if (remaining == LEN_W'(1)) begin
                     state                  <= DONE;
                     done_port              <= 1'b1;
                     mem.Mout_addr_ram      <= '0;
                     mem.Mout_data_ram_size <= '0;
                  end else begin
                     state             <= RD;
                     mem.Mout_oe_ram   <= 1'b1;
                     mem.Mout_addr_ram <= src_ptr + STEP;
                  end
`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
                  wd_count <= '0;
               end else if (wd_count == WD_LAST) begin
                  state                  <= DONE;
                  done_port              <= 1'b1;
                  error                  <= 1'b1;
                  mem.Mout_we_ram        <= 1'b0;
                  mem.Mout_addr_ram      <= '0;
                  mem.Mout_data_ram_size <= '0;
               end else begin
                  wd_count <= wd_count + WD_W'(1);
`endif
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_block_copy_master.sv
// tb/tb_mem_block_copy_master.sv - self-checking bench for mem_block_copy_master

module tb_mem_block_copy_master;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   logic              clock;
   logic              reset;
   logic              start_port;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  n_words;
   logic              done_port;
   logic              error;

   mem_block_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   mem_block_copy_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(64)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start_port (start_port),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .n_words    (n_words),
      .done_port  (done_port),
      .error      (error),
      .mem        (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      string             name;
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [LEN_W-1:0]  n;
      int                rd;
      int                wr;
      int                exp_cyc;
      bit                glitch;
   } vec_t;

   logic [DATA_W-1:0] mem [0:255];
   int checks   = 0;
   int failures = 0;

   int rd_delay  = 1;
   int wr_delay  = 1;
   int wait_cnt  = 0;
   bit never_rdy = 1'b0;
   bit spurious  = 1'b0;

   logic [ADDR_W-1:0] exp_rd_q [$];
   wr_t               exp_wr_q [$];

   int req_cycles, stab_bad, overlap_bad, size_bad, wr_acc;
   logic              prev_oe, prev_we, prev_rdy;
   logic [ADDR_W-1:0] prev_addr;
   logic [DATA_W-1:0] prev_wdata;
   logic [5:0]        prev_size;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // One clock: at the falling edge run the bus monitor, the responder and
   // the scoreboard. A strobe raised here is consumed at the next rising edge.
   task automatic tick();
      logic rdy;
      @(negedge clock);
      if (bus.Mout_oe_ram && bus.Mout_we_ram) overlap_bad++;
      if (bus.Mout_oe_ram || bus.Mout_we_ram) begin
         if (bus.Mout_data_ram_size != 6'd32) size_bad++;
      end else begin
         if (bus.Mout_data_ram_size != 6'd0) size_bad++;
      end
      if ((prev_oe || prev_we) && !prev_rdy && (bus.Mout_oe_ram || bus.Mout_we_ram) &&
          ({bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram, bus.Mout_Wdata_ram, bus.Mout_data_ram_size} !==
           {prev_oe, prev_we, prev_addr, prev_wdata, prev_size}))
         stab_bad++;

      rdy = 1'b0;
      if (!reset) begin
         wait_cnt = 0;
      end else if (bus.Mout_oe_ram || bus.Mout_we_ram) begin
         req_cycles++;
         wait_cnt++;
         rdy = !never_rdy && (wait_cnt == (bus.Mout_oe_ram ? rd_delay : wr_delay));
      end else begin
         rdy = spurious;
      end

      if (rdy && bus.Mout_oe_ram) begin
         wait_cnt = 0;
         if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
         else check("rd_addr", bus.Mout_addr_ram, exp_rd_q.pop_front());
      end
      if (rdy && bus.Mout_we_ram) begin
         wr_t e;
         wait_cnt = 0;
         wr_acc++;
         if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", bus.Mout_addr_ram, e.addr);
            check("wr_data", bus.Mout_Wdata_ram, e.data);
         end
         mem[bus.Mout_addr_ram[9:2]] = bus.Mout_Wdata_ram;
      end

      bus.M_Rdata_ram = (rdy && bus.Mout_oe_ram) ? mem[bus.Mout_addr_ram[9:2]] : 32'hDEAD_BEEF;
      bus.M_DataRdy   = rdy;

      prev_oe    = bus.Mout_oe_ram;
      prev_we    = bus.Mout_we_ram;
      prev_addr  = bus.Mout_addr_ram;
      prev_wdata = bus.Mout_Wdata_ram;
      prev_size  = bus.Mout_data_ram_size;
      prev_rdy   = rdy;
   endtask

   task automatic push_expect(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n);
      for (int i = 0; i < int'(n); i++) begin
         logic [ADDR_W-1:0] ra, wa;
         ra = s + ADDR_W'(4 * i);
         wa = d + ADDR_W'(4 * i);
         exp_rd_q.push_back(ra);
         exp_wr_q.push_back('{wa, mem[ra[9:2]]});
      end
   endtask

   task automatic run_copy(input vec_t v);
      int cyc, got;
      logic err_at_done;
      rd_delay = v.rd; wr_delay = v.wr;
      req_cycles = 0; stab_bad = 0; overlap_bad = 0; size_bad = 0;
      err_at_done = 1'bx;
      push_expect(v.src, v.dst, v.n);
      start_port = 1'b1; src_addr = v.src; dst_addr = v.dst; n_words = v.n;
      tick();
      src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom); n_words = LEN_W'($urandom_range(1, 9));
      cyc = 1; got = -1;
      while (cyc <= 2000) begin
         start_port = (v.glitch && cyc == 3);
         if (done_port) begin
            got = cyc;
            err_at_done = error;
            break;
         end
         tick();
         cyc++;
      end
      start_port = 1'b0;
      check({v.name, " done_latency"}, got, v.exp_cyc);
      check({v.name, " error_at_done"}, err_at_done, 1'b0);
      tick();
      check({v.name, " done_one_cycle"}, done_port, 1'b0);
      check({v.name, " all_accesses_seen"}, exp_rd_q.size() + exp_wr_q.size(), 0);
      check({v.name, " request_cycles"}, req_cycles, v.exp_cyc - 1);
      check({v.name, " held_while_waiting_violations"}, stab_bad, 0);
      check({v.name, " oe_we_overlap"}, overlap_bad, 0);
      check({v.name, " size_violations"}, size_bad, 0);
   endtask

   vec_t vecs [6];

   initial begin
      int cyc, bad;
      vecs[0] = '{"copy_r2w1",     10'h000, 10'h040, 8'd2, 2, 1,  7, 1'b0};
      vecs[1] = '{"zero_len",      10'h100, 10'h200, 8'd0, 1, 1,  1, 1'b0};
      vecs[2] = '{"src_wrap",      10'h3FC, 10'h100, 8'd2, 1, 1,  5, 1'b0};
      vecs[3] = '{"dst_wrap",      10'h200, 10'h3FC, 8'd2, 1, 2,  7, 1'b0};
      vecs[4] = '{"stall_r5",      10'h080, 10'h300, 8'd3, 5, 1, 19, 1'b0};
      vecs[5] = '{"start_ignored", 10'h140, 10'h280, 8'd4, 3, 3, 25, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h1122_3344;
      mem[1] = 32'h5566_7788;

      reset = 1'b0; start_port = 1'b0; src_addr = '0; dst_addr = '0; n_words = '0;
      bus.M_DataRdy = 1'b0; bus.M_Rdata_ram = '0;
      prev_oe = 0; prev_we = 0; prev_rdy = 0; prev_addr = '0; prev_wdata = '0; prev_size = '0;

      @(negedge clock);
      check("reset_outputs",
            {done_port, error, bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram, bus.Mout_Wdata_ram, bus.Mout_data_ram_size}, 0);
      reset = 1'b1;

      // DataRdy strobes while idle must not start anything.
      spurious = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("spurious_rdy_idle", {bus.Mout_oe_ram, bus.Mout_we_ram, done_port}, 3'b000);
      end
      spurious = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_copy(vecs[i]);
         if (i == 0) begin
            check("copy_mem_0x40", mem[10'h040 >> 2], 32'h1122_3344);
            check("copy_mem_0x44", mem[10'h044 >> 2], 32'h5566_7788);
         end
      end

      // Reset during the write of word 3 of 8.
      rd_delay = 1; wr_delay = 3; wr_acc = 0;
      push_expect(10'h080, 10'h180, 8'd8);
      start_port = 1'b1; src_addr = 10'h080; dst_addr = 10'h180; n_words = 8'd8;
      tick();
      start_port = 1'b0;
      cyc = 0;
      while (!(bus.Mout_we_ram && wr_acc == 2) && cyc < 200) begin
         tick();
         cyc++;
      end
      check("reset_reached_wr3", (cyc < 200), 1'b1);
      #2 reset = 1'b0;
      #1 check("reset_async_outputs",
               {done_port, error, bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram, bus.Mout_Wdata_ram, bus.Mout_data_ram_size}, 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done_port) bad++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done_port || bus.Mout_oe_ram || bus.Mout_we_ram) bad++;
      end
      check("reset_no_done_no_request", bad, 0);
      for (int i = 0; i < 8; i++) mem[(10'h180 >> 2) + i] = 32'h0;
      run_copy('{"recopy_after_reset", 10'h080, 10'h180, 8'd8, 1, 3, 33, 1'b0});
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (mem[(10'h180 >> 2) + i] !== mem[(10'h080 >> 2) + i]) bad++;
      check("recopy_mem_words_bad", bad, 0);

`ifdef MEM_BLOCK_COPY_TIMEOUT_EN
      never_rdy = 1'b1;
      req_cycles = 0;
      start_port = 1'b1; src_addr = 10'h000; dst_addr = 10'h040; n_words = 8'd3;
      tick();
      start_port = 1'b0;
      cyc = 1;
      bad = -1;
      while (cyc <= 300) begin
         if (done_port) begin
            bad = cyc;
            check("timeout_error_at_done", error, 1'b1);
            break;
         end
         tick();
         cyc++;
      end
      check("timeout_done_latency", bad, 65);
      check("timeout_oe_cycles", req_cycles, 64);
      tick();
      check("timeout_back_idle", {done_port, bus.Mout_oe_ram, bus.Mout_we_ram}, 3'b000);
      never_rdy = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_block_copy_master.md
Name: mem_block_copy_master

Overview:
- Initiator end of the single-channel minimal memory interface used by HLS-generated designs (oe/we/addr/Wdata/data_ram_size out; Rdata/DataRdy in).
- Copies N consecutive words from a source to a destination address: read word, write word, repeat.
- Used as a preload/readback engine in front of testbench memory models and as a DMA helper beside generated `main` cores.
- Start/done protocol matches the generated cores' start_port/done_port handshake.

Parameters:
- ADDR_W, 10, byte-address width of Mout_addr_ram.
- DATA_W, 32, data word width; must be 8, 16 or 32.
- LEN_W, 8, width of the word-count input.
- TIMEOUT_CYCLES, 64, per-access watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_port  in  1  one-cycle start pulse; sampled only in IDLE.
- src_addr  in  ADDR_W  first source byte address; latched on start.
- dst_addr  in  ADDR_W  first destination byte address; latched on start.
- n_words  in  LEN_W  number of words to copy; latched on start.
- done_port  out  1  one-cycle completion pulse.
- error  out  1  valid while done_port=1; 1 = transfer aborted.
- Mout_oe_ram  out  1  read request.
- Mout_we_ram  out  1  write request.
- Mout_addr_ram  out  ADDR_W  access byte address.
- Mout_Wdata_ram  out  DATA_W  write data.
- Mout_data_ram_size  out  6  access size in bits (constant DATA_W while requesting, else 0).
- M_Rdata_ram  in  DATA_W  read data; valid in the cycle M_DataRdy=1 with oe high.
- M_DataRdy  in  1  access-complete strobe from the responder.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE. All outputs 0: done_port, error, oe, we, addr, Wdata, size. Internal counters cleared.
- Reset mid-transfer: the request is dropped immediately, no done_port pulse is issued, and the partial copy is left in memory.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: on start_port=1, latch src, dst and n_words. If n_words=0, go to DONE. Otherwise go to RD.
  - RD: oe=1, addr=src pointer, size=DATA_W, held stable until M_DataRdy=1. On that cycle, capture M_Rdata_ram into the data register and go to WR.
  - WR: we=1, addr=dst pointer, Wdata=data register, held stable until M_DataRdy=1. On that cycle, advance both pointers by DATA_W/8 and decrement the remaining count. If the count reaches 0, go to DONE; otherwise go to RD.
  - DONE: done_port=1 for exactly one cycle, then return to IDLE.
- oe and we are never high in the same cycle. Requests are registered outputs: oe rises in the cycle after start is sampled.
- Pointer arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- start_port outside IDLE is ignored, not queued.
- M_DataRdy while neither oe nor we is high is ignored.
- Per-word latency against a responder with read delay R and write delay W: R + W cycles. Total cycles from start to done_port = 1 + n_words*(R+W).
- Request signals change only on a cycle where M_DataRdy=1 or on a state change, never while waiting.
- error is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_BLOCK_COPY_TIMEOUT_EN.
- Defined:
  - A watchdog counter restarts at each new RD or WR request and increments every waiting cycle.
  - If TIMEOUT_CYCLES elapse without M_DataRdy, drop oe/we that cycle and go to DONE with error=1.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter logic is instantiated.
  - The block waits indefinitely for M_DataRdy.
  - error is tied to 0.

Test Plan:
- Copy, R=2, W=1: memory holds 0x11223344, 0x55667788 at 0x00/0x04; src=0x00, dst=0x40, n=2 -> 0x40=0x11223344, 0x44=0x55667788; done_port exactly 7 cycles after start is sampled; error=0.
- Zero length: n_words=0 -> done_port in the cycle after start; oe and we never asserted.
- Address wrap, ADDR_W=10: src=0x3FC, n=2 -> second read at 0x000; dst pointer wraps the same way.
- Stall tolerance: responder read delay 5 -> oe, addr and size held stable 5 cycles per read; data intact; total = 1 + n*6 cycles.
- Reset mid-copy: assert reset during WR of word 3 of 8 -> outputs 0 asynchronously; no done_port; a fresh start afterwards copies all 8 words correctly.
- MEM_BLOCK_COPY_TIMEOUT_EN, TIMEOUT_CYCLES=64, responder never asserts DataRdy -> oe drops after 64 waiting cycles; done_port=1 with error=1; FSM back in IDLE.
